// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory-stage LSU and the data memory.
// Single-outstanding valid/grant/rvalid handshake with byte enables.
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_gnt,
    input  dmem_rvalid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_gnt,
    output dmem_rvalid,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Takes the EX/MEM slot, issues one data-memory
// access at a time, lane-formats stores, extends load data for MEM/WB and
// stalls the front of the pipeline while an access is in flight. An access
// that sits in REQ/RESP for TIMEOUT_CYCLES cycles is dropped with bus_err_m.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_m,
  input  logic                  mem_read_m,
  input  logic                  mem_write_m,
  input  logic [2:0]            funct3_m,
  input  logic [31:0]           addr_m,
  input  logic [31:0]           wd_m,
  input  logic [4:0]            rd_m,
  mem_stage_lsu_if.master       dmem,
  output logic                  stall_m,
  output logic                  load_valid_w,
  output logic [31:0]           load_data_w,
  output logic [4:0]            load_rd_w,
  output logic                  misalign_m,
  output logic                  bus_err_m
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Access context captured when the request is issued (stage p1).
  logic [2:0] f3_p1;
  logic [1:0] off_p1;
  logic [4:0] rd_p1;

  logic op;
  logic misaligned;
  logic start;
  logic store_done;
  logic load_done;
  logic timeout;

  // Store data replicated across the lanes the access may touch.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_wdata = {4{wd[7:0]}};
      2'b01:   store_wdata = {2{wd[15:0]}};
      default: store_wdata = wd;
    endcase
  endfunction

  // Byte enables from access size and byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Lane select and sign/zero extension of a returned word.
  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] r;
    b  = word[{off, 3'b000} +: 8];
    h  = off[1] ? word[31:16] : word[15:0];
    sb = $signed(b);
    sh = $signed(h);
    case (f3)
      3'b000:  r = sb;
      3'b001:  r = sh;
      3'b100:  r = $signed({24'd0, b});
      3'b101:  r = $signed({16'd0, h});
      default: r = $signed(word);
    endcase
    load_fmt = r;
  endfunction

  assign op         = valid_m & (mem_read_m | mem_write_m);
  assign misaligned = ((funct3_m[1:0] == 2'b01) & addr_m[0]) |
                      ((funct3_m[1:0] == 2'b10) & (addr_m[1:0] != 2'b00));
  assign start      = (state == ST_IDLE) & op & ~misaligned;
  assign store_done = (state == ST_REQ) & dmem.dmem_we & dmem.dmem_gnt;
  assign load_done  = (state == ST_RESP) & dmem.dmem_rvalid;
  assign timeout    = (state != ST_IDLE) & (cnt == CNT_LAST) & ~store_done & ~load_done;

  assign misalign_m = (state == ST_IDLE) & op & misaligned;
  assign stall_m    = start |
                      (~timeout & (((state == ST_REQ) & ~store_done) |
                                   ((state == ST_RESP) & ~dmem.dmem_rvalid)));

  // Access sequencing, request strobe, timeout counter and bus error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      dmem.dmem_req <= 1'b0;
      bus_err_m     <= 1'b0;
    end else begin
      bus_err_m <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_REQ;
            cnt           <= '0;
            dmem.dmem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          cnt <= cnt + 1'b1;
          if (timeout) begin
            state         <= ST_IDLE;
            dmem.dmem_req <= 1'b0;
            bus_err_m     <= 1'b1;
          end else if (dmem.dmem_gnt) begin
            dmem.dmem_req <= 1'b0;
            state         <= dmem.dmem_we ? ST_IDLE : ST_RESP;
          end
        end
        ST_RESP: begin
          cnt <= cnt + 1'b1;
          if (timeout) begin
            state     <= ST_IDLE;
            bus_err_m <= 1'b1;
          end else if (dmem.dmem_rvalid) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state         <= ST_IDLE;
          dmem.dmem_req <= 1'b0;
        end
      endcase
    end
  end

  // Bus fields and load context, captured once per access and held until the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
      f3_p1           <= '0;
      off_p1          <= '0;
      rd_p1           <= '0;
    end else if (start) begin
      dmem.dmem_we    <= mem_write_m & ~mem_read_m;
      dmem.dmem_addr  <= {addr_m[31:2], 2'b00};
      dmem.dmem_wdata <= store_wdata(funct3_m, wd_m);
      dmem.dmem_be    <= store_be(funct3_m, addr_m[1:0]);
      f3_p1           <= funct3_m;
      off_p1          <= addr_m[1:0];
      rd_p1           <= rd_m;
    end
  end

  // Load result register toward MEM/WB (stage p2); valid pulses one cycle after rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_valid_w <= 1'b0;
      load_data_w  <= '0;
      load_rd_w    <= '0;
    end else begin
      load_valid_w <= load_done;
      if (load_done) begin
        load_data_w <= load_fmt(dmem.dmem_rdata, off_p1, f3_p1);
        load_rd_w   <= rd_p1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stores, loads, misalignment, timeout and
// reset during an access, with the bus responder driven step by step.
module tb_mem_stage_lsu;

  logic        clk;
  logic        reset;
  logic        valid_m;
  logic        mem_read_m;
  logic        mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] addr_m;
  logic [31:0] wd_m;
  logic [4:0]  rd_m;
  logic        stall_m;
  logic        load_valid_w;
  logic [31:0] load_data_w;
  logic [4:0]  load_rd_w;
  logic        misalign_m;
  logic        bus_err_m;

  int n_assert;
  int n_fail;
  int drop;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_m      (valid_m),
    .mem_read_m   (mem_read_m),
    .mem_write_m  (mem_write_m),
    .funct3_m     (funct3_m),
    .addr_m       (addr_m),
    .wd_m         (wd_m),
    .rd_m         (rd_m),
    .dmem         (bus),
    .stall_m      (stall_m),
    .load_valid_w (load_valid_w),
    .load_data_w  (load_data_w),
    .load_rd_w    (load_rd_w),
    .misalign_m   (misalign_m),
    .bus_err_m    (bus_err_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic set_op(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
    valid_m     = v;
    mem_read_m  = rd_en;
    mem_write_m = wr_en;
    funct3_m    = f3;
    addr_m      = a;
    wd_m        = wd;
    rd_m        = r;
  endtask

  task automatic bus_drive(input logic g, input logic rv, input logic [31:0] rdat);
    bus.dmem_gnt    = g;
    bus.dmem_rvalid = rv;
    bus.dmem_rdata  = rdat;
  endtask

  // Advance to the next cycle: inputs change at the falling edge, checks follow 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    bus_drive(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);

    // Reset state
    next_cycle(); #1;
    chk("rst_req", bus.dmem_req, 1'b0);
    chk("rst_we", bus.dmem_we, 1'b0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_wdata", bus.dmem_wdata, 32'h0);
    chk("rst_be", bus.dmem_be, 4'h0);
    chk("rst_lv", load_valid_w, 1'b0);
    chk("rst_ld", load_data_w, 32'h0);
    chk("rst_lrd", load_rd_w, 5'd0);
    chk("rst_berr", bus_err_m, 1'b0);
    chk("rst_stall", stall_m, 1'b0);
    chk("rst_mis", misalign_m, 1'b0);
    reset = 1'b0;

    // SW 0x100 <- DEADBEEF, grant in first REQ cycle
    next_cycle();
    set_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0); #1;
    chk("sw_idle_stall", stall_m, 1'b1);
    chk("sw_idle_req", bus.dmem_req, 1'b0);
    next_cycle();
    bus_drive(1'b1, 1'b0, 32'h0); #1;
    chk("sw_req", bus.dmem_req, 1'b1);
    chk("sw_we", bus.dmem_we, 1'b1);
    chk("sw_addr", bus.dmem_addr, 32'h100);
    chk("sw_be", bus.dmem_be, 4'b1111);
    chk("sw_wdata", bus.dmem_wdata, 32'hDEADBEEF);
    chk("sw_gnt_stall", stall_m, 1'b0);
    next_cycle();
    bus_drive(1'b0, 1'b0, 32'h0);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0); #1;
    chk("sw_req_drop", bus.dmem_req, 1'b0);
    chk("sw_after_stall", stall_m, 1'b0);

    // SB 0x203 <- A5, one wait cycle before grant
    next_cycle();
    set_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 5'd0); #1;
    chk("sb_idle_stall", stall_m, 1'b1);
    next_cycle(); #1;
    chk("sb_wait_req", bus.dmem_req, 1'b1);
    chk("sb_wait_stall", stall_m, 1'b1);
    chk("sb_be", bus.dmem_be, 4'b1000);
    chk("sb_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
    chk("sb_addr", bus.dmem_addr, 32'h200);
    next_cycle();
    bus_drive(1'b1, 1'b0, 32'h0); #1;
    chk("sb_hold_req", bus.dmem_req, 1'b1);
    chk("sb_gnt_stall", stall_m, 1'b0);
    next_cycle();
    bus_drive(1'b0, 1'b0, 32'h0);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0); #1;
    chk("sb_req_drop", bus.dmem_req, 1'b0);

    // SH 0x102 <- 0x1234, immediate grant
    next_cycle();
    set_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'hFFFF1234, 5'd0); #1;
    next_cycle();
    bus_drive(1'b1, 1'b0, 32'h0); #1;
    chk("sh_be", bus.dmem_be, 4'b1100);
    chk("sh_wdata", bus.dmem_wdata, 32'h12341234);
    next_cycle();
    bus_drive(1'b0, 1'b0, 32'h0);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);

    // LB 0x102 rd=7: grant after 2 waits, rvalid on the 3rd RESP cycle
    next_cycle();
    set_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 5'd7); #1;
    chk("lb_idle_stall", stall_m, 1'b1);
    next_cycle(); #1;
    chk("lb_req", bus.dmem_req, 1'b1);
    chk("lb_we", bus.dmem_we, 1'b0);
    chk("lb_addr", bus.dmem_addr, 32'h100);
    next_cycle(); #1;
    chk("lb_wait2_stall", stall_m, 1'b1);
    next_cycle();
    bus_drive(1'b1, 1'b0, 32'h0); #1;
    chk("lb_gnt_stall", stall_m, 1'b1);
    next_cycle();
    bus_drive(1'b0, 1'b0, 32'h0); #1;
    chk("lb_resp_req", bus.dmem_req, 1'b0);
    chk("lb_resp_stall", stall_m, 1'b1);
    next_cycle(); #1;
    chk("lb_resp2_lv", load_valid_w, 1'b0);
    next_cycle();
    bus_drive(1'b0, 1'b1, 32'h00FF8000); #1;
    chk("lb_rv_stall", stall_m, 1'b0);
    next_cycle();
    bus_drive(1'b0, 1'b0, 32'h0);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0); #1;
    chk("lb_lv", load_valid_w, 1'b1);
    chk("lb_data", load_data_w, 32'hFFFFFFFF);
    chk("lb_rd", load_rd_w, 5'd7);
    next_cycle(); #1;
    chk("lb_lv_pulse", load_valid_w, 1'b0);
    chk("lb_data_hold", load_data_w, 32'hFFFFFFFF);

    // LBU 0x102 rd=3: immediate grant, rvalid next cycle -> 2 stall cycles
    next_cycle();
    set_op(1'b1, 1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 5'd3); #1;
    chk("lbu_stall1", stall_m, 1'b1);
    next_cycle();
    bus_drive(1'b1, 1'b0, 32'h0); #1;
    chk("lbu_stall2", stall_m, 1'b1);
    next_cycle();
    bus_drive(1'b0, 1'b1, 32'h00FF8000); #1;
    chk("lbu_stall3", stall_m, 1'b0);
    next_cycle();
    bus_drive(1'b0, 1'b0, 32'h0);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0); #1;
    chk("lbu_lv", load_valid_w, 1'b1);
    chk("lbu_data", load_data_w, 32'h000000FF);
    chk("lbu_rd", load_rd_w, 5'd3);

    // LH 0x101 misaligned
    next_cycle();
    set_op(1'b1, 1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 5'd4); #1;
    chk("lh_mis", misalign_m, 1'b1);
    chk("lh_mis_stall", stall_m, 1'b0);
    next_cycle();
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0); #1;
    chk("lh_mis_noreq", bus.dmem_req, 1'b0);
    chk("lh_mis_clear", misalign_m, 1'b0);

    // LHU 0x102 rd=5 rdata 80001234
    next_cycle();
    set_op(1'b1, 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd5); #1;
    chk("lhu_mis", misalign_m, 1'b0);
    next_cycle();
    bus_drive(1'b1, 1'b0, 32'h0);
    next_cycle();
    bus_drive(1'b0, 1'b1, 32'h80001234);
    next_cycle();
    bus_drive(1'b0, 1'b0, 32'h0);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0); #1;
    chk("lhu_lv", load_valid_w, 1'b1);
    chk("lhu_data", load_data_w, 32'h00008000);

    // LW rd=0 with both read and write set: treated as a load, still pulses
    next_cycle();
    set_op(1'b1, 1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 5'd0); #1;
    next_cycle();
    bus_drive(1'b1, 1'b0, 32'h0); #1;
    chk("lw0_we", bus.dmem_we, 1'b0);
    chk("lw0_gnt_stall", stall_m, 1'b1);
    next_cycle();
    bus_drive(1'b0, 1'b1, 32'h12345678);
    next_cycle();
    bus_drive(1'b0, 1'b0, 32'h0);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0); #1;
    chk("lw0_lv", load_valid_w, 1'b1);
    chk("lw0_data", load_data_w, 32'h12345678);
    chk("lw0_rd", load_rd_w, 5'd0);

    // LW 0x400 with grant but no rvalid: timeout
    next_cycle();
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd8); #1;
    next_cycle();
    bus_drive(1'b1, 1'b0, 32'h0); #1;
    drop = 0;
    for (int k = 1; k <= 100; k++) begin
      next_cycle();
      bus_drive(1'b0, 1'b0, 32'h0); #1;
      if (!stall_m) begin
        drop = k;
        break;
      end
    end
    chk("to_drop_cycle", drop, 32'd63);
    chk("to_drop_berr", bus_err_m, 1'b0);
    next_cycle();
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0); #1;
    chk("to_berr", bus_err_m, 1'b1);
    chk("to_lv", load_valid_w, 1'b0);
    chk("to_req", bus.dmem_req, 1'b0);
    chk("to_stall", stall_m, 1'b0);
    next_cycle(); #1;
    chk("to_berr_pulse", bus_err_m, 1'b0);
    chk("to_lv2", load_valid_w, 1'b0);

    // LW 0x500 rd=9, reset while in RESP, then a late rvalid
    next_cycle();
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd9); #1;
    next_cycle();
    bus_drive(1'b1, 1'b0, 32'h0); #1;
    next_cycle();
    bus_drive(1'b0, 1'b0, 32'h0);
    reset = 1'b1; #1;
    chk("rr_resp_stall", stall_m, 1'b1);
    next_cycle();
    reset = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    bus_drive(1'b0, 1'b1, 32'hCAFEF00D); #1;
    chk("rr_req", bus.dmem_req, 1'b0);
    chk("rr_addr", bus.dmem_addr, 32'h0);
    chk("rr_be", bus.dmem_be, 4'h0);
    chk("rr_ld", load_data_w, 32'h0);
    chk("rr_lrd", load_rd_w, 5'd0);
    chk("rr_berr", bus_err_m, 1'b0);
    chk("rr_stall", stall_m, 1'b0);
    next_cycle();
    bus_drive(1'b0, 1'b0, 32'h0); #1;
    chk("rr_late_lv", load_valid_w, 1'b0);
    chk("rr_late_ld", load_data_w, 32'h0);

    // Unit is usable again after the abandoned access
    next_cycle();
    set_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h600, 32'h11223344, 5'd0); #1;
    chk("post_stall", stall_m, 1'b1);
    next_cycle();
    bus_drive(1'b1, 1'b0, 32'h0); #1;
    chk("post_req", bus.dmem_req, 1'b1);
    chk("post_addr", bus.dmem_addr, 32'h600);
    next_cycle();
    bus_drive(1'b0, 1'b0, 32'h0);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
